// File: rtl/nbody_pkg.sv
// Shared types, constants and saturation helper for the N-body integrator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nbody_pkg;

  localparam int REC_W     = 80;
  localparam int ADDR_W    = 15;
  localparam int IDX_W     = 6;
  localparam int ACC_DEPTH = 1 << IDX_W;
  localparam int R2_W      = 36;

  typedef logic signed [15:0] fix16_t;
  typedef logic signed [31:0] acc_t;

  typedef struct packed {
    fix16_t      pos_x;
    fix16_t      pos_y;
    fix16_t      vel_x;
    fix16_t      vel_y;
    logic [15:0] mass;
  } body_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_I,
    S_RD_J,
    S_CALC,
    S_DIV,
    S_ACC,
    S_UPD_RD,
    S_UPD_WR,
    S_DONE
  } state_t;

  // Clamp a 33-bit signed value into the signed 16-bit range.
  function automatic fix16_t sat16(input logic signed [32:0] v);
    if (v > 33'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -33'sd32768) begin
      return fix16_t'(16'h8000);
    end
    return v[15:0];
  endfunction

endpackage

// File: rtl/nbody_body_ram.sv
// Body record store: one registered read port, one write port.
// Latency: read data 1 cycle after address; writes land on the clock edge.
// Backpressure: none; contents survive reset, only the read register clears.
module nbody_body_ram
  import nbody_pkg::*;
#(
  parameter int DEPTH     = 1 << ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [REC_W-1:0]  rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [REC_W-1:0]  wr_data
);

  logic [REC_W-1:0] mem [DEPTH];

  // Array write, no reset so the image persists.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/nbody_divider.sv
// Signed-by-unsigned sequential restoring divider, quotient truncates toward zero.
// Latency: NUM_W cycles after start; done pulses one cycle with quo valid until next start.
// Backpressure: none; start is assumed only while idle, the caller waits for done.
module nbody_divider #(
  parameter int NUM_W = 42,
  parameter int DEN_W = 36
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [NUM_W-1:0] num,
  input  logic [DEN_W-1:0]        den,
  output logic signed [NUM_W-1:0] quo,
  output logic                    done
);

  logic [NUM_W-1:0] q;
  logic [DEN_W:0]   rem;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   trial;
  logic             trial_ok;
  logic             neg;
  logic             busy;
  logic [7:0]       cnt;

  // One restoring step: bring in the next dividend bit and try to subtract.
  always_comb begin
    shifted  = {rem[DEN_W-1:0], q[NUM_W-1]};
    trial    = shifted - {1'b0, den};
    trial_ok = (shifted >= {1'b0, den});
  end

  assign quo = neg ? -$signed(q) : $signed(q);

  // Magnitude division, sign restored on the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      rem  <= '0;
      neg  <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        q    <= num[NUM_W-1] ? $unsigned(-num) : $unsigned(num);
        rem  <= '0;
        neg  <= num[NUM_W-1];
        busy <= 1'b1;
        cnt  <= 8'(NUM_W);
      end else if (busy) begin
        rem <= trial_ok ? trial : shifted;
        q   <= {q[NUM_W-2:0], trial_ok};
        cnt <= cnt - 8'd1;
        if (cnt == 8'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/nbody_sim.sv
// 2-D gravitational N-body step: all-pairs accelerations, then semi-implicit Euler update.
// Latency: data dependent, about N*(N-1)*(SHIFT+40) cycles from start to done.
// Backpressure: start ignored while busy; host reads honoured only when idle.
// Build option NBODY_FORCE_DUMP_EN: also write saturated per-body forces at FORCE_BASE+k.
module nbody_sim
  import nbody_pkg::*;
#(
  parameter int          N          = 2,
  parameter int          SHIFT      = 8,
  parameter int          EPS        = 1,
  parameter logic [14:0] FORCE_BASE = 15'h190,
  parameter              INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic [14:0] host_rd_addr,
  output logic [79:0] host_rd_data
);

  localparam int                NUM_W = 34 + SHIFT;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N - 1);

  state_t             state;
  logic [IDX_W-1:0]   i_idx, j_idx, k_idx;
  fix16_t             xi_r, yi_r;
  logic signed [16:0] dx_r, dy_r;
  logic [15:0]        mj_r;
  logic               div_start;
  acc_t               acc_x [ACC_DEPTH];
  acc_t               acc_y [ACC_DEPTH];
`ifdef NBODY_FORCE_DUMP_EN
  logic               wr_phase;
`endif

  logic [ADDR_W-1:0]  rd_addr, wr_addr, k_addr;
  logic [REC_W-1:0]   ram_q, wr_data;
  logic               we;
  body_t              cur;

  logic signed [NUM_W-1:0] mj_ext, dx_ext, dy_ext, num_x, num_y, quo_x, quo_y;
  logic signed [R2_W-1:0]  dx36, dy36;
  logic [R2_W-1:0]         r2;
  logic                    done_x, done_y;

  fix16_t sax, say, vx_new, vy_new, px_new, py_new;
  body_t  new_body;

  assign cur          = body_t'(ram_q);
  assign host_rd_data = ram_q;
  assign k_addr       = {{(ADDR_W-IDX_W){1'b0}}, k_idx};

  // Read address: FSM owns the port while busy, host otherwise.
  always_comb begin
    rd_addr = host_rd_addr;
    case (state)
      S_RD_I:             rd_addr = {{(ADDR_W-IDX_W){1'b0}}, i_idx};
      S_RD_J:             rd_addr = {{(ADDR_W-IDX_W){1'b0}}, j_idx};
      S_UPD_RD, S_UPD_WR: rd_addr = k_addr;
      default:            rd_addr = host_rd_addr;
    endcase
  end

  // Divider operands: scaled mass*displacement over softened squared distance.
  always_comb begin
    mj_ext = {{(NUM_W-16){1'b0}}, mj_r};
    dx_ext = {{(NUM_W-17){dx_r[16]}}, dx_r};
    dy_ext = {{(NUM_W-17){dy_r[16]}}, dy_r};
    num_x  = (mj_ext * dx_ext) <<< SHIFT;
    num_y  = (mj_ext * dy_ext) <<< SHIFT;
    dx36   = {{(R2_W-17){dx_r[16]}}, dx_r};
    dy36   = {{(R2_W-17){dy_r[16]}}, dy_r};
    r2     = dx36 * dx36 + dy36 * dy36 + R2_W'(EPS);
  end

  nbody_divider #(.NUM_W(NUM_W), .DEN_W(R2_W)) u_div_x (
    .clk(clk), .reset(reset), .start(div_start),
    .num(num_x), .den(r2), .quo(quo_x), .done(done_x)
  );

  nbody_divider #(.NUM_W(NUM_W), .DEN_W(R2_W)) u_div_y (
    .clk(clk), .reset(reset), .start(div_start),
    .num(num_y), .den(r2), .quo(quo_y), .done(done_y)
  );

  // Body update for index k: kick velocity, then drift position with the new velocity.
  always_comb begin
    sax    = sat16({acc_x[k_idx][31], acc_x[k_idx]});
    say    = sat16({acc_y[k_idx][31], acc_y[k_idx]});
    vx_new = sat16({{17{cur.vel_x[15]}}, cur.vel_x} + {{17{sax[15]}}, sax});
    vy_new = sat16({{17{cur.vel_y[15]}}, cur.vel_y} + {{17{say[15]}}, say});
    px_new = sat16({{17{cur.pos_x[15]}}, cur.pos_x} + {{17{vx_new[15]}}, vx_new});
    py_new = sat16({{17{cur.pos_y[15]}}, cur.pos_y} + {{17{vy_new[15]}}, vy_new});
    new_body = '{pos_x: px_new, pos_y: py_new, vel_x: vx_new, vel_y: vy_new, mass: cur.mass};
  end

  // Write port: body write-back, plus optional force record on its own cycle.
  always_comb begin
    we      = 1'b0;
    wr_addr = k_addr;
    wr_data = new_body;
    if (state == S_UPD_WR) begin
`ifdef NBODY_FORCE_DUMP_EN
      if (wr_phase) begin
        we      = 1'b1;
        wr_addr = FORCE_BASE + k_addr;
        wr_data = {48'h0, sax, say};
      end else begin
        we = (k_addr < FORCE_BASE);
      end
`else
      we = (k_addr < FORCE_BASE);
`endif
    end
  end

  nbody_body_ram #(.INIT_FILE(INIT_FILE)) u_ram (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(ram_q),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Step sequencer: pair loop over (i,j) skipping self, then per-body update pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      xi_r      <= '0;
      yi_r      <= '0;
      dx_r      <= '0;
      dy_r      <= '0;
      mj_r      <= '0;
      div_start <= 1'b0;
`ifdef NBODY_FORCE_DUMP_EN
      wr_phase  <= 1'b0;
`endif
      for (int n = 0; n < ACC_DEPTH; n++) begin
        acc_x[n] <= '0;
        acc_y[n] <= '0;
      end
    end else begin
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done  <= 1'b0;
            i_idx <= '0;
            j_idx <= '0;
            for (int n = 0; n < ACC_DEPTH; n++) begin
              acc_x[n] <= '0;
              acc_y[n] <= '0;
            end
            state <= S_RD_I;
          end
        end
        S_RD_I: begin
          if (j_idx == i_idx) begin
            if (j_idx == LAST) begin
              if (i_idx == LAST) begin
                k_idx <= '0;
                state <= S_UPD_RD;
              end else begin
                i_idx <= i_idx + 1'b1;
                j_idx <= '0;
              end
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            state <= S_RD_J;
          end
        end
        S_RD_J: begin
          xi_r  <= cur.pos_x;
          yi_r  <= cur.pos_y;
          state <= S_CALC;
        end
        S_CALC: begin
          dx_r      <= {cur.pos_x[15], cur.pos_x} - {xi_r[15], xi_r};
          dy_r      <= {cur.pos_y[15], cur.pos_y} - {yi_r[15], yi_r};
          mj_r      <= cur.mass;
          div_start <= 1'b1;
          state     <= S_DIV;
        end
        S_DIV: begin
          if (done_x && done_y) begin
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc_x[i_idx] <= acc_x[i_idx] + acc_t'(quo_x[31:0]);
          acc_y[i_idx] <= acc_y[i_idx] + acc_t'(quo_y[31:0]);
          if (j_idx == LAST) begin
            if (i_idx == LAST) begin
              k_idx <= '0;
              state <= S_UPD_RD;
            end else begin
              i_idx <= i_idx + 1'b1;
              j_idx <= '0;
              state <= S_RD_I;
            end
          end else begin
            j_idx <= j_idx + 1'b1;
            state <= S_RD_I;
          end
        end
        S_UPD_RD: begin
          state <= S_UPD_WR;
        end
        S_UPD_WR: begin
`ifdef NBODY_FORCE_DUMP_EN
          wr_phase <= ~wr_phase;
          if (wr_phase) begin
`else
          begin
`endif
            if (k_idx == LAST) begin
              state <= S_DONE;
            end else begin
              k_idx <= k_idx + 1'b1;
              state <= S_UPD_RD;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbody_sim.sv
// Directed + randomized bench for nbody_sim against an arithmetic reference model.
// Latency: waits on done with a bounded cycle budget per step.
// Backpressure: exercises start-while-busy and reset mid-step.
module tb_nbody_sim;

  localparam int          N          = 2;
  localparam int          SHIFT      = 8;
  localparam int          EPS        = 1;
  localparam logic [14:0] FORCE_BASE = 15'h190;
  localparam int          STEP_BOUND = N * N * (40 + SHIFT);
  localparam logic [79:0] SENTINEL   = 80'hA5A5_5A5A_C3C3_3C3C_0F0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [14:0] host_rd_addr;
  logic [79:0] host_rd_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_px [N];
  logic [15:0] m_py [N];
  logic [15:0] m_vx [N];
  logic [15:0] m_vy [N];
  logic [15:0] m_ms [N];
  logic [15:0] f_x  [N];
  logic [15:0] f_y  [N];

  nbody_sim #(.N(N), .SHIFT(SHIFT), .EPS(EPS), .FORCE_BASE(FORCE_BASE), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_l(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [79:0] rec(input int a);
    return {m_px[a], m_py[a], m_vx[a], m_vy[a], m_ms[a]};
  endfunction

  // Reference timestep: plain integer physics straight from the rules.
  task automatic model_step();
    int     ax [N];
    int     ay [N];
    longint dx, dy, r2, tx, ty;
    for (int a = 0; a < N; a++) begin
      ax[a] = 0;
      ay[a] = 0;
    end
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) begin
        if (a != b) begin
          dx = longint'($signed(m_px[b])) - longint'($signed(m_px[a]));
          dy = longint'($signed(m_py[b])) - longint'($signed(m_py[a]));
          r2 = dx * dx + dy * dy + EPS;
          tx = (longint'(m_ms[b]) * dx * (longint'(1) << SHIFT)) / r2;
          ty = (longint'(m_ms[b]) * dy * (longint'(1) << SHIFT)) / r2;
          ax[a] = ax[a] + int'(tx);
          ay[a] = ay[a] + int'(ty);
        end
      end
    end
    for (int a = 0; a < N; a++) begin
      f_x[a]  = sat_l(longint'(ax[a]));
      f_y[a]  = sat_l(longint'(ay[a]));
      m_vx[a] = sat_l(longint'($signed(m_vx[a])) + longint'($signed(f_x[a])));
      m_vy[a] = sat_l(longint'($signed(m_vy[a])) + longint'($signed(f_y[a])));
      m_px[a] = sat_l(longint'($signed(m_px[a])) + longint'($signed(m_vx[a])));
      m_py[a] = sat_l(longint'($signed(m_py[a])) + longint'($signed(m_vy[a])));
    end
  endtask

  task automatic set_body(input int a, input logic [15:0] px, input logic [15:0] py,
                          input logic [15:0] vx, input logic [15:0] vy, input logic [15:0] ms);
    m_px[a] = px; m_py[a] = py; m_vx[a] = vx; m_vy[a] = vy; m_ms[a] = ms;
    dut.u_ram.mem[15'(a)] <= {px, py, vx, vy, ms};
  endtask

  task automatic read_rec(input logic [14:0] addr, output logic [79:0] d);
    @(negedge clk);
    host_rd_addr = addr;
    @(negedge clk);
    d = host_rd_data;
  endtask

  task automatic check_bodies(input string tag);
    logic [79:0] d;
    for (int a = 0; a < N; a++) begin
      read_rec(15'(a), d);
      chk($sformatf("%s_body%0d", tag, a), d, rec(a));
    end
  endtask

  task automatic check_forces(input string tag);
    logic [79:0] d;
    for (int a = 0; a < N; a++) begin
      read_rec(FORCE_BASE + 15'(a), d);
`ifdef NBODY_FORCE_DUMP_EN
      chk($sformatf("%s_force%0d", tag, a), d, {48'h0, f_x[a], f_y[a]});
`else
      chk($sformatf("%s_force%0d", tag, a), d, SENTINEL);
`endif
    end
  endtask

  // One accepted start, bounded wait for done, then advance the model.
  task automatic run_step(input string tag);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_clr"}, 80'(done), 80'(0));
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 80'(done), 80'(1));
    checks++;
    assert (cyc <= STEP_BOUND) else begin
      errors++;
      $error("FAIL %s_latency: observed %0d cycles required <= %0d", tag, cyc, STEP_BOUND);
    end
    model_step();
  endtask

  initial begin
    logic [79:0] d;
    int          cyc;
    int          rises;
    logic        prev;

    reset        = 1'b1;
    start        = 1'b0;
    host_rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_done", 80'(done), 80'(0));
    chk("reset_rd_data", host_rd_data, 80'h0);
    reset = 1'b0;
    for (int a = 0; a < N; a++) begin
      dut.u_ram.mem[FORCE_BASE + 15'(a)] <= SENTINEL;
    end

    // Two-body reference case.
    set_body(0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1);
    set_body(1, 16'd16, 16'd0, 16'd0, 16'd0, 16'd4);
    run_step("basic");
    read_rec(15'd0, d);
    chk("basic_addr0", d, 80'h003F_0000_003F_0000_0001);
    read_rec(15'd1, d);
    chk("basic_addr1", d, 80'h0001_0000_FFF1_0000_0004);
    check_forces("basic");

    // Coincident bodies: zero force, positions unchanged.
    set_body(0, 16'd100, 16'hFFCE, 16'd0, 16'd0, 16'd500);
    set_body(1, 16'd100, 16'hFFCE, 16'd0, 16'd0, 16'hFFFF);
    run_step("coinc");
    read_rec(15'd0, d);
    chk("coinc_addr0", d, 80'h0064_FFCE_0000_0000_01F4);
    check_bodies("coinc");
    check_forces("coinc");

    // Saturation toward +x edge.
    set_body(0, 16'h7FF0, 16'd0, 16'h7F00, 16'd0, 16'd1);
    set_body(1, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    run_step("sat");
    read_rec(15'd0, d);
    chk("sat_addr0", d, 80'h7FFF_0000_7FFF_0000_0001);
    read_rec(15'd1, d);
    chk("sat_addr1", d, 80'h7FEF_0000_FFF0_0000_FFFF);
    check_forces("sat");

    // Randomized bodies; last round also chains a second step.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < N; a++) begin
        if (r == 2) begin
          set_body(a, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end else begin
          set_body(a, 16'($urandom_range(0, 8000)) - 16'd4000,
                      16'($urandom_range(0, 8000)) - 16'd4000,
                      16'($urandom_range(0, 200)) - 16'd100,
                      16'($urandom_range(0, 200)) - 16'd100,
                      16'($urandom));
        end
      end
      run_step($sformatf("rand%0d", r));
      check_bodies($sformatf("rand%0d", r));
      check_forces($sformatf("rand%0d", r));
    end
    run_step("chain");
    check_bodies("chain");

    // Reset in the middle of a divide, then a clean step.
    for (int a = 0; a < N; a++) begin
      set_body(a, 16'($urandom_range(0, 2000)) - 16'd1000,
                  16'($urandom_range(0, 2000)) - 16'd1000,
                  16'd5, 16'hFFFB, 16'($urandom));
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_done", 80'(done), 80'(0));
    chk("midrst_rd_data", host_rd_data, 80'h0);
    @(negedge clk);
    reset = 1'b0;
    check_bodies("midrst_ram");
    run_step("midrst_fresh");
    check_bodies("midrst_fresh");

    // start pulses while busy are ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    rises = 0;
    prev  = done;
    while (rises == 0 && cyc < 1000) begin
      start = (cyc == 5 || cyc == 40 || cyc == 80);
      @(negedge clk);
      cyc++;
      if (done && !prev) rises++;
      prev = done;
    end
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done && !prev) rises++;
      prev = done;
    end
    chk("busy_start_rises", 80'(rises), 80'(1));
    chk("busy_start_done", 80'(done), 80'(1));
    model_step();
    check_bodies("busy_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
